psw_cond_unit: RTL and testbench
================================

# psw_cond_unit

Execute-stage companion to the ALU, sitting directly downstream of it and feeding it back. It takes the ALU's Z/N/C/V flags and result LSB each cycle and evaluates the instruction's PA-RISC completer condition to decide whether the next instruction is nullified. It also holds the PSW carry bit that drives the ALU's `Ci` input, and counts nullified instructions.

## Interface
- `CNT_W`, default 16: width of the nullified-instruction counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  a real instruction occupies EX this cycle.
- `stall`  in  1  pipeline hold; no state changes.
- `flush`  in  1  squash EX and all pending nullify state.
- `alu_z`, `alu_n`, `alu_c`, `alu_v`  in  1 each  ALU flags for the EX instruction.
- `alu_lsb`  in  1  bit 0 of ALU `Out`.
- `flag_we`  in  1  EX instruction is a flag-setting op (ALU OP 0000–0011); it updates the PSW carry.
- `cond_en`  in  1  EX instruction carries a nullify condition.
- `cond`  in  3  condition select.
- `cond_f`  in  1  negate the condition.
- `cnt_clr`  in  1  synchronous clear of `nul_cnt`.
- `psw_c`  out  1  registered PSW carry; drives ALU `Ci`.
- `nullify_next`  out  1  registered; the next valid instruction must be squashed.
- `ex_squash`  out  1  combinational; the current EX instruction is nullified.
- `nul_cnt`  out  CNT_W  saturating count of squashed instructions.

## Operation
**Condition decode** (`cond`), evaluated on the flags of a subtraction A−B, where `C` is the 33-bit borrow:
- 0 never: 0
- 1 `=`: Z
- 2 `<`: N^V
- 3 `<=`: (N^V)|Z
- 4 `<<`: C
- 5 `<<=`: C|Z
- 6 SV: V
- 7 OD: `alu_lsb`
- Result: `hit = eval(cond) ^ cond_f`.

**State machine:** states IDLE and PEND; `nullify_next` is 1 exactly in PEND.
- `ex_squash` = PEND & `ex_valid`.
- An instruction is "live" when `ex_valid & ~ex_squash & ~stall & ~flush`.
- IDLE → PEND: live & `cond_en` & `hit`.
- PEND → IDLE: `ex_valid & ~stall`. The squashed instruction's own `cond_en` and `flag_we` are ignored, so a nullified instruction can never re-arm PEND.
- PEND with `ex_valid=0` (bubble): hold PEND.
- `flush` (any state, not gated by stall): → IDLE.

**PSW carry:**
- `psw_c` ← `alu_c` on live & `flag_we`; otherwise hold.
- Flush and squash never modify `psw_c`.

**Counter:**
- `nul_cnt` increments on PEND→IDLE via squash, saturating at all-ones.
- `cnt_clr` takes priority over the increment.

## Timing
- Reset (async assert, sync-safe deassert): `psw_c=0`, state IDLE, `nullify_next=0`, `nul_cnt=0`.
- `ex_squash` is combinational from state and `ex_valid`, so it is valid in the same cycle.
- Condition latency: 1 cycle. `hit` in cycle t gives `nullify_next=1` in cycle t+1.
- `psw_c` is visible to the ALU the cycle after the writing instruction, so back-to-back ADDC/SUBB chains see the correct carry.
- `stall=1` freezes every register, including the counter. `cnt_clr` still acts during stall.
- Priority: `rst_n` > `flush` > `stall` > normal update.
- Reset asserted mid-PEND returns to IDLE at once; no squash leaks past reset.

## Structure
- Shared package `parisc_pkg` holds:
  - condition codes `COND_NEVER`…`COND_OD` as 3-bit localparams;
  - state enum `{ST_IDLE, ST_PEND}`;
  - ALU OP constants, used by the decoder to derive `flag_we`.
- One sub-module, `cond_eval`: purely combinational. Inputs are flags, `alu_lsb`, `cond` and `cond_f`; output is `hit`.
- The top module holds the FSM, the `psw_c` register and the counter.

## Test plan
- **Signed-less-than with overflow.** Drive A=0x9C000038, B=0x70000003 subtraction flags (Z=0, N=0, C=0, V=1) with `cond=2`, `cond_en=1`. Required: `nullify_next=1` next cycle, then `ex_squash=1` on the following valid instruction, `nul_cnt=1`.
- **Carry chain.** An ADD with `alu_c=1` and `flag_we=1`, then `psw_c=1` the next cycle. A squashed ADD with `alu_c=0` leaves `psw_c=1`. A live ADD with `alu_c=0` clears it.
- **Bubble and stall while PEND.** Insert `ex_valid=0` for 2 cycles, then `stall=1` for 3 cycles. Required: `nullify_next` stays 1 throughout; the first valid unstalled instruction is squashed and the state returns to IDLE.
- **Nullified instruction carries a true condition.** The squashed instruction has `cond_en=1` with `cond=1`, Z=1. Required: state goes IDLE and the following instruction is not squashed.
- **Flush, negation and never.** Flush in PEND gives `nullify_next=0` next cycle with `psw_c` unchanged. `cond=0`, `cond_f=1` always nullifies. `cond=0`, `cond_f=0` never nullifies.
- **Counter saturation and reset.** With `CNT_W=4`, perform 17 squashes: `nul_cnt=0xF`. Then `cnt_clr` gives 0. Async `rst_n` low mid-PEND zeroes all outputs immediately.

Source files
------------

// File: rtl/parisc_pkg.sv
// Shared PA-RISC execute-stage definitions: condition codes, nullify FSM
// states and ALU opcodes. The flag-setting opcodes are what the decoder uses
// to derive flag_we.
package parisc_pkg;

  localparam int unsigned COND_W   = 3;
  localparam int unsigned ALU_OP_W = 4;

  // Completer condition select, evaluated on the flags of A-B
  localparam logic [COND_W-1:0] COND_NEVER = 3'd0;
  localparam logic [COND_W-1:0] COND_EQ    = 3'd1;
  localparam logic [COND_W-1:0] COND_LT    = 3'd2;
  localparam logic [COND_W-1:0] COND_LE    = 3'd3;
  localparam logic [COND_W-1:0] COND_LTU   = 3'd4;
  localparam logic [COND_W-1:0] COND_LEU   = 3'd5;
  localparam logic [COND_W-1:0] COND_SV    = 3'd6;
  localparam logic [COND_W-1:0] COND_OD    = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Flag-setting ALU ops occupy 0000-0011
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDC = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBB = 4'b0011;

  function automatic logic is_flag_op(input logic [ALU_OP_W-1:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/psw_cond_unit_cond_eval.sv
// Combinational evaluation of the nullify condition.
// Inputs : alu_z/n/c/v flags, alu_lsb, cond select, cond_f negate
// Output : hit = eval(cond) ^ cond_f
module cond_eval
  import parisc_pkg::*;
(
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_lsb,
  input  logic [COND_W-1:0] cond,
  input  logic              cond_f,
  output logic              hit
);

  logic eval;

  always_comb begin
    eval = 1'b0;
    case (cond)
      COND_NEVER: eval = 1'b0;
      COND_EQ:    eval = alu_z;
      COND_LT:    eval = alu_n ^ alu_v;
      COND_LE:    eval = (alu_n ^ alu_v) | alu_z;
      COND_LTU:   eval = alu_c;
      COND_LEU:   eval = alu_c | alu_z;
      COND_SV:    eval = alu_v;
      COND_OD:    eval = alu_lsb;
      default:    eval = 1'b0;
    endcase
    hit = eval ^ cond_f;
  end

endmodule

// File: rtl/psw_cond_unit.sv
// Execute-stage PSW/condition unit: evaluates the completer condition to
// nullify the next instruction, holds the PSW carry fed back to the ALU and
// counts nullified instructions.
// Inputs : ex_valid, stall, flush, ALU flags + lsb, flag_we, cond_en,
//          cond, cond_f, cnt_clr
// Outputs: psw_c, nullify_next (registered), ex_squash (combinational),
//          nul_cnt (saturating)
module psw_cond_unit
  import parisc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_lsb,
  input  logic              flag_we,
  input  logic              cond_en,
  input  logic [COND_W-1:0] cond,
  input  logic              cond_f,
  input  logic              cnt_clr,
  output logic              psw_c,
  output logic              nullify_next,
  output logic              ex_squash,
  output logic [CNT_W-1:0]  nul_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             psw_c_q, psw_c_d;
  logic [CNT_W-1:0] nul_cnt_q, nul_cnt_d;
  logic             hit;
  logic             live;
  logic             squash_evt;

  cond_eval u_cond_eval (
    .alu_z   (alu_z),
    .alu_n   (alu_n),
    .alu_c   (alu_c),
    .alu_v   (alu_v),
    .alu_lsb (alu_lsb),
    .cond    (cond),
    .cond_f  (cond_f),
    .hit     (hit)
  );

  // State register, PSW carry and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      psw_c_q   <= 1'b0;
      nul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      psw_c_q   <= psw_c_d;
      nul_cnt_q <= nul_cnt_d;
    end
  end

  // Next-state, carry and counter update
  always_comb begin
    state_d    = state_q;
    psw_c_d    = psw_c_q;
    nul_cnt_d  = nul_cnt_q;
    ex_squash  = (state_q == ST_PEND) & ex_valid;
    live       = ex_valid & ~ex_squash & ~stall & ~flush;
    // Only a real squash (not a flush) retires the pending nullify as a count
    squash_evt = ex_squash & ~stall & ~flush;

    if (flush) begin
      state_d = ST_IDLE;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: if (live && cond_en && hit) state_d = ST_PEND;
        // Squashed instruction's own cond_en is ignored, so it cannot re-arm
        ST_PEND: if (ex_valid) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (live && flag_we) psw_c_d = alu_c;

    // Clear wins over increment and still acts during stall
    if (cnt_clr) begin
      nul_cnt_d = '0;
    end else if (squash_evt && (nul_cnt_q != CNT_MAX)) begin
      nul_cnt_d = nul_cnt_q + CNT_W'(1);
    end
  end

  assign psw_c        = psw_c_q;
  assign nullify_next = (state_q == ST_PEND);
  assign nul_cnt      = nul_cnt_q;

endmodule

// File: tb/tb_psw_cond_unit.sv
// Self-checking bench for psw_cond_unit (CNT_W=4).
module tb_psw_cond_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, stall, flush;
  logic             alu_z, alu_n, alu_c, alu_v, alu_lsb;
  logic             flag_we, cond_en, cond_f, cnt_clr;
  logic [2:0]       cond;
  logic             psw_c, nullify_next, ex_squash;
  logic [CNT_W-1:0] nul_cnt;

  always #5 clk = ~clk;

  psw_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .stall        (stall),
    .flush        (flush),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .alu_lsb      (alu_lsb),
    .flag_we      (flag_we),
    .cond_en      (cond_en),
    .cond         (cond),
    .cond_f       (cond_f),
    .cnt_clr      (cnt_clr),
    .psw_c        (psw_c),
    .nullify_next (nullify_next),
    .ex_squash    (ex_squash),
    .nul_cnt      (nul_cnt)
  );

  typedef struct {
    logic       v, st, fl, z, n, c, ov, lsb, we, ce, cf, clr;
    logic [2:0] cd;
  } in_t;

  typedef struct {
    logic             psw;
    logic             nn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       z, n, c, v, lsb;
    logic [2:0] cd;
    logic       cf, exp_nn;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic             m_pend, m_psw;
  logic [CNT_W-1:0] m_cnt;
  exp_t             sb[$];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_hit(input in_t i);
    logic e;
    case (i.cd)
      3'd0: e = 1'b0;
      3'd1: e = i.z;
      3'd2: e = i.n ^ i.ov;
      3'd3: e = (i.n ^ i.ov) | i.z;
      3'd4: e = i.c;
      3'd5: e = i.c | i.z;
      3'd6: e = i.ov;
      default: e = i.lsb;
    endcase
    return e ^ i.cf;
  endfunction

  function automatic in_t nop();
    in_t i;
    i = '{v:1'b0, st:1'b0, fl:1'b0, z:1'b0, n:1'b0, c:1'b0, ov:1'b0, lsb:1'b0,
          we:1'b0, ce:1'b0, cf:1'b0, clr:1'b0, cd:3'd0};
    return i;
  endfunction

  function automatic in_t instr();
    in_t i;
    i = nop();
    i.v = 1'b1;
    return i;
  endfunction

  // Valid compare that always hits (never, negated)
  function automatic in_t arm();
    in_t i;
    i = instr();
    i.ce = 1'b1;
    i.cf = 1'b1;
    return i;
  endfunction

  task automatic drive(input in_t i);
    ex_valid = i.v;   stall = i.st;  flush = i.fl;
    alu_z = i.z;      alu_n = i.n;   alu_c = i.c;   alu_v = i.ov;
    alu_lsb = i.lsb;  flag_we = i.we; cond_en = i.ce;
    cond = i.cd;      cond_f = i.cf; cnt_clr = i.clr;
  endtask

  // One cycle: drive, check combinational squash, predict, clock, compare
  task automatic step(input in_t i);
    logic exp_sq, live;
    exp_t e;
    drive(i);
    #1;
    exp_sq = m_pend & i.v;
    check1("ex_squash", 32'(ex_squash), 32'(exp_sq));
    live = i.v & ~exp_sq & ~i.st & ~i.fl;
    if (i.clr) e.cnt = '0;
    else if (exp_sq && !i.st && !i.fl && m_cnt != 4'hF) e.cnt = m_cnt + 4'd1;
    else e.cnt = m_cnt;
    e.psw = (live && i.we) ? i.c : m_psw;
    if (i.fl) e.nn = 1'b0;
    else if (i.st) e.nn = m_pend;
    else if (m_pend) e.nn = ~i.v;
    else e.nn = live & i.ce & ref_hit(i);
    m_pend = e.nn; m_psw = e.psw; m_cnt = e.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check1("psw_c", 32'(psw_c), 32'(e.psw));
    check1("nullify_next", 32'(nullify_next), 32'(e.nn));
    check1("nul_cnt", 32'(nul_cnt), 32'(e.cnt));
  endtask

  vec_t tbl [13];
  in_t  s;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};

    // Reset
    m_pend = 1'b0; m_psw = 1'b0; m_cnt = '0;
    rst_n = 1'b0;
    drive(nop());
    repeat (2) @(posedge clk);
    #1;
    check1("rst psw_c", 32'(psw_c), 32'd0);
    check1("rst nullify_next", 32'(nullify_next), 32'd0);
    check1("rst nul_cnt", 32'(nul_cnt), 32'd0);
    check1("rst ex_squash", 32'(ex_squash), 32'd0);
    rst_n = 1'b1;
    step(nop());

    // Signed less-than with overflow: 0x9C000038 - 0x70000003
    s = instr(); s.ce = 1'b1; s.cd = 3'd2; s.ov = 1'b1;
    step(s);
    check1("slt nullify_next", 32'(nullify_next), 32'd1);
    step(instr());
    check1("slt nul_cnt", 32'(nul_cnt), 32'd1);

    // Condition table
    for (int k = 0; k < 13; k++) begin
      s = instr(); s.ce = 1'b1;
      s.z = tbl[k].z; s.n = tbl[k].n; s.c = tbl[k].c; s.ov = tbl[k].v;
      s.lsb = tbl[k].lsb; s.cd = tbl[k].cd; s.cf = tbl[k].cf;
      step(s);
      check1($sformatf("tbl[%0d] nullify_next", k), 32'(nullify_next), 32'(tbl[k].exp_nn));
      if (tbl[k].exp_nn) step(instr());
    end

    // Carry chain: set, squashed clear ignored, live clear
    s = instr(); s.we = 1'b1; s.c = 1'b1;
    step(s);
    check1("carry set", 32'(psw_c), 32'd1);
    step(arm());
    s = instr(); s.we = 1'b1; s.c = 1'b0;
    step(s);
    check1("carry squashed hold", 32'(psw_c), 32'd1);
    step(s);
    check1("carry live clear", 32'(psw_c), 32'd0);

    // Bubbles then stall while pending
    step(arm());
    step(nop());
    step(nop());
    s = instr(); s.st = 1'b1;
    repeat (3) step(s);
    check1("stall hold nullify_next", 32'(nullify_next), 32'd1);
    step(instr());
    check1("after stall nullify_next", 32'(nullify_next), 32'd0);

    // Squashed instruction carrying a true condition cannot re-arm
    step(arm());
    s = instr(); s.ce = 1'b1; s.cd = 3'd1; s.z = 1'b1;
    step(s);
    check1("no rearm", 32'(nullify_next), 32'd0);
    step(instr());

    // Flush while pending leaves psw_c alone
    s = instr(); s.we = 1'b1; s.c = 1'b1;
    step(s);
    step(arm());
    s = instr(); s.fl = 1'b1; s.we = 1'b1; s.c = 1'b0;
    step(s);
    check1("flush nullify_next", 32'(nullify_next), 32'd0);
    check1("flush psw_c", 32'(psw_c), 32'd1);
    s = instr(); s.ce = 1'b1;
    step(s);
    check1("never", 32'(nullify_next), 32'd0);

    // Clear during stall, then saturation
    s = nop(); s.st = 1'b1; s.clr = 1'b1;
    step(s);
    check1("clr in stall", 32'(nul_cnt), 32'd0);
    for (int k = 0; k < 17; k++) begin
      step(arm());
      step(instr());
    end
    check1("saturate", 32'(nul_cnt), 32'hF);
    s = nop(); s.clr = 1'b1;
    step(s);
    check1("clr", 32'(nul_cnt), 32'd0);

    // Async reset mid-PEND
    s = instr(); s.we = 1'b1; s.c = 1'b1;
    step(s);
    step(arm());
    step(instr());
    step(arm());
    drive(instr());
    #2;
    rst_n = 1'b0;
    #1;
    check1("areset nullify_next", 32'(nullify_next), 32'd0);
    check1("areset ex_squash", 32'(ex_squash), 32'd0);
    check1("areset psw_c", 32'(psw_c), 32'd0);
    check1("areset nul_cnt", 32'(nul_cnt), 32'd0);
    m_pend = 1'b0; m_psw = 1'b0; m_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(instr());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
